// File: rtl/ppi_ctrl_word_unit.sv
// 8255-style control word unit: decodes mode-set words into group A/B modes and
// port directions, and applies bit set/reset words to the port C output latch.
module ppi_ctrl_word_unit #(
    parameter logic [7:0] RESET_CW = 8'h9B,
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic [1:0] mode_a,
    output logic       mode_b,
    output logic       dir_a,
    output logic       dir_cu,
    output logic       dir_b,
    output logic       dir_cl,
    output logic [7:0] pc_out,
    output logic [7:0] cw_rd,
    output logic       cfg_pulse,
    output logic       bsr_pulse,
    output logic       err_mode
);

    // Bit 6 dominates bit 5, so the nonstandard 2'b11 field still lands in mode 2.
    function automatic logic [1:0] decode_mode_a(input logic [7:0] cw);
        logic [1:0] m;
        if (cw[6]) begin
            m = 2'd2;
        end else if (cw[5]) begin
            m = 2'd1;
        end else begin
            m = 2'd0;
        end
        return m;
    endfunction

    logic [1:0] mode_a_q, mode_a_d;
    logic       mode_b_q, mode_b_d;
    logic       dir_a_q, dir_a_d;
    logic       dir_cu_q, dir_cu_d;
    logic       dir_b_q, dir_b_d;
    logic       dir_cl_q, dir_cl_d;
    logic [7:0] pc_out_q, pc_out_d;
    logic [7:0] cw_rd_q, cw_rd_d;
    logic       cfg_pulse_q, cfg_pulse_d;
    logic       bsr_pulse_q, bsr_pulse_d;
    logic       err_mode_q, err_mode_d;

    // Next-state decode of a write; everything holds and pulses drop when idle.
    always_comb begin
        mode_a_d    = mode_a_q;
        mode_b_d    = mode_b_q;
        dir_a_d     = dir_a_q;
        dir_cu_d    = dir_cu_q;
        dir_b_d     = dir_b_q;
        dir_cl_d    = dir_cl_q;
        pc_out_d    = pc_out_q;
        cw_rd_d     = cw_rd_q;
        err_mode_d  = err_mode_q;
        cfg_pulse_d = 1'b0;
        bsr_pulse_d = 1'b0;
        if (wr_en) begin
            if (din[7]) begin
                mode_a_d    = decode_mode_a(din);
                dir_a_d     = din[4];
                dir_cu_d    = din[3];
                mode_b_d    = din[2];
                dir_b_d     = din[1];
                dir_cl_d    = din[0];
                cw_rd_d     = din;
                pc_out_d    = 8'h00;
                cfg_pulse_d = 1'b1;
                if (din[6:5] == 2'b11) begin
                    err_mode_d = 1'b1;
                end else begin
                    err_mode_d = err_mode_q;
                end
            end else begin
                pc_out_d[din[3:1]] = din[0];
                bsr_pulse_d        = 1'b1;
            end
        end else begin
            cfg_pulse_d = 1'b0;
            bsr_pulse_d = 1'b0;
        end
    end

    // State registers; reset wins over a simultaneous write, which is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_a_q    <= decode_mode_a(RESET_CW);
            dir_a_q     <= RESET_CW[4];
            dir_cu_q    <= RESET_CW[3];
            mode_b_q    <= RESET_CW[2];
            dir_b_q     <= RESET_CW[1];
            dir_cl_q    <= RESET_CW[0];
            cw_rd_q     <= RESET_CW;
            pc_out_q    <= PC_RESET;
            cfg_pulse_q <= 1'b0;
            bsr_pulse_q <= 1'b0;
            err_mode_q  <= 1'b0;
        end else begin
            mode_a_q    <= mode_a_d;
            dir_a_q     <= dir_a_d;
            dir_cu_q    <= dir_cu_d;
            mode_b_q    <= mode_b_d;
            dir_b_q     <= dir_b_d;
            dir_cl_q    <= dir_cl_d;
            cw_rd_q     <= cw_rd_d;
            pc_out_q    <= pc_out_d;
            cfg_pulse_q <= cfg_pulse_d;
            bsr_pulse_q <= bsr_pulse_d;
            err_mode_q  <= err_mode_d;
        end
    end

    assign mode_a    = mode_a_q;
    assign mode_b    = mode_b_q;
    assign dir_a     = dir_a_q;
    assign dir_cu    = dir_cu_q;
    assign dir_b     = dir_b_q;
    assign dir_cl    = dir_cl_q;
    assign pc_out    = pc_out_q;
    assign cw_rd     = cw_rd_q;
    assign cfg_pulse = cfg_pulse_q;
    assign bsr_pulse = bsr_pulse_q;
    assign err_mode  = err_mode_q;

endmodule

// File: doc/ppi_ctrl_word_unit.md
PPI_CTRL_WORD_UNIT -- requirements
Module: ppi_ctrl_word_unit

Interface
REQ-001 The block SHALL have parameter RESET_CW, default 8'h9B, the control word applied at reset (all ports input, mode 0).
REQ-002 The block SHALL have parameter PC_RESET, default 8'h00, the port C output latch value at reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1, write strobe; din is sampled on any edge where it is high.
REQ-006 The block SHALL have port din, input, 8, the written control word.
REQ-007 The block SHALL have port mode_a, output, 2, group A mode (0, 1 or 2).
REQ-008 The block SHALL have port mode_b, output, 1, group B mode (0 or 1).
REQ-009 The block SHALL have ports dir_a, dir_cu, dir_b and dir_cl, output, 1 each, direction of port A, port C upper, port B and port C lower (1 = input).
REQ-010 The block SHALL have port pc_out, output, 8, the port C output latch.
REQ-011 The block SHALL have port cw_rd, output, 8, readback of the last accepted mode-set word.
REQ-012 The block SHALL have ports cfg_pulse and bsr_pulse, output, 1 each, single-cycle acceptance strobes.
REQ-013 The block SHALL have port err_mode, output, 1, sticky flag for a nonstandard group A mode field.

Function
REQ-014 A write with din[7]=1 SHALL be a mode-set word; a write with din[7]=0 SHALL be a bit set/reset (BSR) word.
REQ-015 Mode-set decode SHALL be: mode_a = 2 if din[6]=1, else 1 if din[5]=1, else 0; dir_a = din[4]; dir_cu = din[3]; mode_b = din[2]; dir_b = din[1]; dir_cl = din[0].
REQ-016 A mode-set write SHALL load cw_rd with din, clear pc_out to 8'h00, and assert cfg_pulse for exactly the following cycle.
REQ-017 A mode-set write with din[6:5]=2'b11 SHALL be accepted as mode 2 and SHALL set err_mode, which stays high until reset.
REQ-018 A BSR write SHALL set pc_out[din[3:1]] to din[0], leave all other pc_out bits and all mode/direction outputs and cw_rd unchanged, and assert bsr_pulse for exactly the following cycle.
REQ-019 BSR din[6:4] SHALL be ignored.
REQ-020 Latency SHALL be one cycle: outputs reflect a write on the edge that samples wr_en high, and are visible from that edge onward.
REQ-021 Back-to-back writes on consecutive cycles SHALL each be applied in order with no lost write; the pulse outputs then stay high for consecutive cycles.
REQ-022 With wr_en low, all outputs except the pulses SHALL hold their values, and both pulses SHALL be low.
REQ-023 BSR writes SHALL be honoured in every mode, including port C bits used as handshake lines in modes 1 and 2.
REQ-024 All outputs SHALL be registered, with no combinational path from din or wr_en to any output.

Reset
REQ-025 On an edge with rst high, the block SHALL decode RESET_CW as in REQ-015 and load cw_rd = RESET_CW, pc_out = PC_RESET, cfg_pulse = 0, bsr_pulse = 0 and err_mode = 0.
REQ-026 rst SHALL take priority over a simultaneous wr_en; such a write SHALL be discarded, not deferred.
REQ-027 An illegal RESET_CW with bit 7 = 0 SHALL still be decoded per REQ-015 field positions.

Verification
REQ-028 The bench SHALL check reset defaults: rst for 2 cycles -> cw_rd=8'h9B, mode_a=0, mode_b=0, all dir=1, pc_out=8'h00, pulses=0, err_mode=0.
REQ-029 The bench SHALL check a mode-set write: din=8'hC5 -> next cycle mode_a=2, dir_a=0, dir_cu=0, mode_b=1, dir_b=0, dir_cl=1, cw_rd=8'hC5, cfg_pulse=1 for one cycle, err_mode=0.
REQ-030 The bench SHALL check BSR writes: din=8'h0F then 8'h07 then 8'h0E -> pc_out goes 8'h80, then 8'h88, then 8'h08; bsr_pulse high for 3 consecutive cycles; cw_rd unchanged.
REQ-031 The bench SHALL check that a mode-set clears port C: pc_out=8'h08, then write din=8'h80 -> pc_out=8'h00, mode_a=0, all dir=0.
REQ-032 The bench SHALL check the nonstandard mode: din=8'hE0 -> mode_a=2, err_mode=1 and still 1 after a later write of 8'h80; rst -> err_mode=0.
REQ-033 The bench SHALL check reset priority: rst and wr_en high together with din=8'h0F -> pc_out=PC_RESET, bsr_pulse=0.
